// File: rtl/mixed_dotp_sequencer_pkg.sv
// ============================================================================
// Module      : riscv_defines (package)
// Description : Shared types, widths and the mixed-precision ratio decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_defines;

   localparam int NBITS_MIXED_CYCLES = 3;

   typedef enum logic [3:0] {
      FMT_INT16  = 4'd0,
      FMT_INT8   = 4'd1,
      FMT_INT4   = 4'd2,
      FMT_INT2   = 4'd3,
      MIXED_2x4  = 4'd4,
      MIXED_4x8  = 4'd5,
      MIXED_8x16 = 4'd6,
      MIXED_2x8  = 4'd7,
      MIXED_4x16 = 4'd8,
      MIXED_2x16 = 4'd9
   } ivec_mode_fmt;

   typedef enum logic [0:0] {
      MDS_IDLE  = 1'b0,
      MDS_ISSUE = 1'b1
   } mds_state_e;

   // Ratios are stored as ratio-1 so they compare directly with the slice index.
   localparam logic [NBITS_MIXED_CYCLES-1:0] MDS_RATIO_1 = 3'd0;
   localparam logic [NBITS_MIXED_CYCLES-1:0] MDS_RATIO_2 = 3'd1;
   localparam logic [NBITS_MIXED_CYCLES-1:0] MDS_RATIO_4 = 3'd3;
   localparam logic [NBITS_MIXED_CYCLES-1:0] MDS_RATIO_8 = 3'd7;

   function automatic logic [NBITS_MIXED_CYCLES-1:0] mixed_ratio_m1(ivec_mode_fmt fmt);
      logic [NBITS_MIXED_CYCLES-1:0] r;
      case (fmt)
         MIXED_2x4, MIXED_4x8, MIXED_8x16: r = MDS_RATIO_2;
         MIXED_2x8, MIXED_4x16:            r = MDS_RATIO_4;
         MIXED_2x16:                       r = MDS_RATIO_8;
         default:                          r = MDS_RATIO_1;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mixed_dotp_sequencer.sv
// ============================================================================
// Module      : mixed_dotp_sequencer
// Description : Splits one mixed-precision dotp request into per-slice uops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mixed_dotp_sequencer
   import riscv_defines::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  ivec_mode_fmt                  req_fmt_i,
   input  logic                          req_accum_i,
   output logic                          uop_valid_o,
   input  logic                          uop_ready_i,
   output logic [NBITS_MIXED_CYCLES-1:0] uop_slice_o,
   output logic                          uop_accum_o,
   output logic                          uop_last_o,
   input  logic                          flush_i,
   output logic                          busy_o,
   output logic                          done_o
);

   mds_state_e                    r_state;
   mds_state_e                    w_state_nxt;
   logic [NBITS_MIXED_CYCLES-1:0] r_slice;
   logic [NBITS_MIXED_CYCLES-1:0] r_last;
   logic                          r_accum;
   logic                          r_done;

   logic                          w_accept;
   logic                          w_hs;
   logic                          w_is_last;

   assign w_is_last = (r_slice == r_last);

   always_comb begin
      w_state_nxt = r_state;
      req_ready_o = 1'b0;
      uop_valid_o = 1'b0;
      busy_o      = 1'b0;
      w_accept    = 1'b0;
      w_hs        = 1'b0;
      case (r_state)
         MDS_IDLE: begin
            req_ready_o = !flush_i;
            w_accept    = req_valid_i && !flush_i;
            if (w_accept) begin
               w_state_nxt = MDS_ISSUE;
            end
         end
         MDS_ISSUE: begin
            uop_valid_o = 1'b1;
            busy_o      = 1'b1;
            // A handshake coinciding with a flush is dropped by the consumer too.
            w_hs        = uop_ready_i && !flush_i;
            if (flush_i) begin
               w_state_nxt = MDS_IDLE;
            end else if (w_hs && w_is_last) begin
               w_state_nxt = MDS_IDLE;
            end
         end
         default: begin
            w_state_nxt = MDS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= MDS_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slice <= '0;
         r_last  <= '0;
         r_accum <= 1'b0;
         r_done  <= 1'b0;
      end else if (flush_i) begin
         r_slice <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_last  <= mixed_ratio_m1(req_fmt_i);
            r_accum <= req_accum_i;
            r_slice <= '0;
         end else if (w_hs) begin
            if (w_is_last) begin
               r_slice <= '0;
               r_done  <= 1'b1;
            end else begin
               r_slice <= r_slice + 1'b1;
            end
         end
      end
   end

   // Config flops keep stale values in IDLE, so qualify the uop fields by state.
   assign uop_slice_o = r_slice;
   assign uop_last_o  = (r_state == MDS_ISSUE) && w_is_last;
   assign uop_accum_o = (r_state == MDS_ISSUE) && (r_accum || (r_slice != '0));
   assign done_o      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mixed_dotp_sequencer.sv
// ============================================================================
// Module      : tb_mixed_dotp_sequencer
// Description : Directed and random checks of mixed_dotp_sequencer vs a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mixed_dotp_sequencer;
   import riscv_defines::*;

   logic                          clk = 1'b0;
   logic                          rst_n;
   logic                          req_valid;
   logic                          req_ready_o;
   ivec_mode_fmt                  req_fmt;
   logic                          req_accum;
   logic                          uop_valid_o;
   logic                          uop_ready;
   logic [NBITS_MIXED_CYCLES-1:0] uop_slice_o;
   logic                          uop_accum_o;
   logic                          uop_last_o;
   logic                          flush;
   logic                          busy_o;
   logic                          done_o;

   int checks   = 0;
   int errors   = 0;
   int hs_cnt   = 0;
   int done_cnt = 0;

   bit m_active;
   bit m_acc;
   bit m_done;
   int m_idx;
   int m_n;

   logic [NBITS_MIXED_CYCLES-1:0] held_slice;

   always #5 clk = ~clk;

   mixed_dotp_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready_o),
      .req_fmt_i   (req_fmt),
      .req_accum_i (req_accum),
      .uop_valid_o (uop_valid_o),
      .uop_ready_i (uop_ready),
      .uop_slice_o (uop_slice_o),
      .uop_accum_o (uop_accum_o),
      .uop_last_o  (uop_last_o),
      .flush_i     (flush),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   function automatic int ref_ratio(ivec_mode_fmt f);
      case (f)
         MIXED_2x4, MIXED_4x8, MIXED_8x16: return 2;
         MIXED_2x8, MIXED_4x16:            return 4;
         MIXED_2x16:                       return 8;
         default:                          return 1;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_acc    = 1'b0;
      m_done   = 1'b0;
      m_idx    = 0;
      m_n      = 1;
   endtask

   // Compare every output against the model, before the edge.
   task automatic model_check();
      check("req_ready", 32'(req_ready_o), 32'(!m_active && !flush));
      check("uop_valid", 32'(uop_valid_o), 32'(m_active));
      check("busy",      32'(busy_o),      32'(m_active));
      check("slice",     32'(uop_slice_o), m_active ? 32'(m_idx) : 32'd0);
      check("last",      32'(uop_last_o),  32'(m_active && (m_idx == m_n - 1)));
      check("accum",     32'(uop_accum_o), 32'(m_active && (m_acc || m_idx > 0)));
      check("done",      32'(done_o),      32'(m_done));
      if (uop_valid_o && uop_ready && !flush) hs_cnt++;
      if (done_o) done_cnt++;
   endtask

   task automatic model_step();
      if (!rst_n) begin
         model_reset();
      end else if (flush) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_idx    = 0;
      end else begin
         m_done = 1'b0;
         if (!m_active && req_valid) begin
            m_active = 1'b1;
            m_n      = ref_ratio(req_fmt);
            m_acc    = req_accum;
            m_idx    = 0;
         end else if (m_active && uop_ready) begin
            if (m_idx == m_n - 1) begin
               m_active = 1'b0;
               m_done   = 1'b1;
               m_idx    = 0;
            end else begin
               m_idx++;
            end
         end
      end
   endtask

   task automatic cyc();
      #1;
      model_check();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_fmt   = FMT_INT16;
      req_accum = 1'b0;
      uop_ready = 1'b0;
      flush     = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready_o), 32'd1);
      check("rst_uop_valid", 32'(uop_valid_o), 32'd0);
      check("rst_busy",      32'(busy_o),      32'd0);
      check("rst_done",      32'(done_o),      32'd0);
      check("rst_slice",     32'(uop_slice_o), 32'd0);
      check("rst_last",      32'(uop_last_o),  32'd0);
      check("rst_accum",     32'(uop_accum_o), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Ratio 2, no stall
      req_valid = 1'b1; req_fmt = MIXED_4x8; req_accum = 1'b0; uop_ready = 1'b1;
      cyc();
      req_valid = 1'b0;
      #1;
      check("r2_s0_slice", 32'(uop_slice_o), 32'd0);
      check("r2_s0_accum", 32'(uop_accum_o), 32'd0);
      check("r2_s0_last",  32'(uop_last_o),  32'd0);
      cyc();
      #1;
      check("r2_s1_slice", 32'(uop_slice_o), 32'd1);
      check("r2_s1_accum", 32'(uop_accum_o), 32'd1);
      check("r2_s1_last",  32'(uop_last_o),  32'd1);
      cyc();
      #1;
      check("r2_done",     32'(done_o),      32'd1);
      check("r2_ready",    32'(req_ready_o), 32'd1);
      cyc();
      #1;
      check("r2_done_one_cycle", 32'(done_o), 32'd0);

      // Ratio 8 with alternating backpressure; format changes mid-sequence are ignored
      hs_cnt = 0; done_cnt = 0;
      req_valid = 1'b1; req_fmt = MIXED_2x16; req_accum = 1'b1; uop_ready = 1'b0;
      cyc();
      req_valid = 1'b0; req_fmt = FMT_INT8; req_accum = 1'b0;
      for (int i = 0; i < 16; i++) begin
         uop_ready = i[0];
         if (!i[0]) begin
            #1 held_slice = uop_slice_o;
         end else begin
            #1 check("r8_held", 32'(uop_slice_o), 32'(held_slice));
         end
         cyc();
      end
      uop_ready = 1'b1;
      cyc();
      cyc();
      check("r8_handshakes", 32'(hs_cnt),   32'd8);
      check("r8_done_cnt",   32'(done_cnt), 32'd1);

      // Non-mixed format
      req_valid = 1'b1; req_fmt = FMT_INT8; req_accum = 1'b1; uop_ready = 1'b1;
      cyc();
      req_valid = 1'b0;
      #1;
      check("nm_slice", 32'(uop_slice_o), 32'd0);
      check("nm_last",  32'(uop_last_o),  32'd1);
      check("nm_accum", 32'(uop_accum_o), 32'd1);
      cyc();
      cyc();

      // Flush after the slice-1 handshake
      done_cnt = 0;
      req_valid = 1'b1; req_fmt = MIXED_2x8; req_accum = 1'b0; uop_ready = 1'b1;
      cyc();
      req_valid = 1'b0;
      cyc();
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      #1;
      check("fl_valid_low", 32'(uop_valid_o), 32'd0);
      cyc();
      cyc();
      check("fl_no_done", 32'(done_cnt), 32'd0);
      req_valid = 1'b1; req_fmt = MIXED_4x16;
      cyc();
      req_valid = 1'b0;
      #1;
      check("fl_restart_slice", 32'(uop_slice_o), 32'd0);
      check("fl_restart_valid", 32'(uop_valid_o), 32'd1);
      for (int i = 0; i < 5; i++) cyc();

      // Back-to-back requests with req_valid held high
      req_valid = 1'b1; req_fmt = MIXED_8x16; req_accum = 1'b0; uop_ready = 1'b1;
      cyc();
      req_fmt = MIXED_2x8; req_accum = 1'b1;
      cyc();
      cyc();
      #1;
      check("b2b_done",   32'(done_o),      32'd1);
      check("b2b_accept", 32'(req_ready_o), 32'd1);
      cyc();
      req_valid = 1'b0;
      #1;
      check("b2b_valid", 32'(uop_valid_o), 32'd1);
      check("b2b_slice", 32'(uop_slice_o), 32'd0);
      check("b2b_accum", 32'(uop_accum_o), 32'd1);
      for (int i = 0; i < 5; i++) cyc();

      // Asynchronous reset at slice 2 of ratio 4
      req_valid = 1'b1; req_fmt = MIXED_2x8; req_accum = 1'b1; uop_ready = 1'b1;
      cyc();
      req_valid = 1'b0;
      cyc();
      cyc();
      #1;
      check("ar_slice2", 32'(uop_slice_o), 32'd2);
      rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(uop_valid_o), 32'd0);
      check("ar_busy",  32'(busy_o),      32'd0);
      check("ar_slice", 32'(uop_slice_o), 32'd0);
      check("ar_last",  32'(uop_last_o),  32'd0);
      check("ar_accum", 32'(uop_accum_o), 32'd0);
      check("ar_done",  32'(done_o),      32'd0);
      check("ar_ready", 32'(req_ready_o), 32'd1);
      model_reset();
      @(negedge clk);
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         req_valid = ($urandom_range(0, 1) == 1);
         req_fmt   = ivec_mode_fmt'(4'($urandom_range(0, 15)));
         req_accum = ($urandom_range(0, 1) == 1);
         uop_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         cyc();
      end
      req_valid = 1'b0; flush = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
